exe_stage: RTL

- Execute stage plus EXE/MEM pipeline register, sitting directly downstream of the ID/EXE register.
- Consumes the registered decode bundle from ID/EXE: control bits, 4-bit ALU code, destination register number, operands A and B, and the sign-extended immediate.
- Computes the ALU result and registers it, together with the forwarded control bits, into the MEM stage.
- Adds an iterative 32-cycle shift-add multiplier that stalls the upstream stages while it runs.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/seq_multiplier.sv | 51 +++++
 rtl/exe_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: ALU codes, EXE FSM encoding
// and the datapath width.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0001;
  localparam logic [3:0] ALUC_AND = 4'b0010;
  localparam logic [3:0] ALUC_OR  = 4'b0011;
  localparam logic [3:0] ALUC_XOR = 4'b0100;
  localparam logic [3:0] ALUC_SLT = 4'b0101;
  localparam logic [3:0] ALUC_SLL = 4'b0110;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_LUI = 4'b1000;
  localparam logic [3:0] ALUC_MUL = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DONE = 2'd2
  } exe_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W cycles,
// keeps the low DATA_W bits of the product.
module seq_multiplier #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == CNT_W'(DATA_W - 1)) r_busy <= 1'b0;
    end else if (start) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end
  end

  // done flags the cycle doing the final iteration; product is complete after that edge.
  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == CNT_W'(DATA_W - 1));
  assign product = r_acc;

endmodule

// File: rtl/exe_stage.sv
// Execute stage with EXE/MEM register; MUL runs on the sequential multiplier
// and stalls the upstream stages until its result is ready.
module exe_stage #(
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  input  logic              ealuimm,
  input  logic [3:0]        ealuc,
  input  logic [4:0]        emux,
  input  logic [DATA_W-1:0] eRegOutA,
  input  logic [DATA_W-1:0] eRegOutB,
  input  logic [DATA_W-1:0] eExtended,
  output logic              stall,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic [4:0]        mmux,
  output logic [DATA_W-1:0] mAluOut,
  output logic [DATA_W-1:0] mRegOutB
);

  import mips_pkg::*;

  function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
      ALUC_ADD: res = a + b;
      ALUC_SUB: res = a - b;
      ALUC_AND: res = a & b;
      ALUC_OR:  res = a | b;
      ALUC_XOR: res = a ^ b;
      ALUC_SLT: res = DATA_W'($signed(a) < $signed(b));
      ALUC_SLL: res = a << b[4:0];
      ALUC_SRL: res = a >> b[4:0];
      ALUC_LUI: res = b << 16;
      default:  res = '0;
    endcase
    return res;
  endfunction

  exe_state_e        r_state;
  exe_state_e        w_state_nxt;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu;
  logic              w_is_mul;
  logic              w_mul_start;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_product;
  logic              w_stall;

  assign w_b      = ealuimm ? eExtended : eRegOutB;
  assign w_alu    = alu_f(ealuc, eRegOutA, w_b);
  assign w_is_mul = (ealuc == ALUC_MUL);

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .clrn    (clrn),
    .start   (w_mul_start),
    .a       (eRegOutA),
    .b       (w_b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_product)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // DONE never looks at ealuc, so the MUL still held in ID/EXE cannot re-trigger.
  always_comb begin
    w_state_nxt = r_state;
    w_mul_start = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_is_mul) begin
        w_mul_start = 1'b1;
        w_stall     = 1'b1;
        w_state_nxt = ST_MULT;
      end
      ST_MULT: begin
        w_stall = 1'b1;
        if (w_mul_done)       w_state_nxt = ST_DONE;
        else if (!w_mul_busy) w_state_nxt = ST_IDLE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset also masks stall so upstream stages are released immediately.
  assign stall = w_stall & clrn;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mwreg    <= 1'b0;
      mm2reg   <= 1'b0;
      mwmem    <= 1'b0;
      mmux     <= '0;
      mAluOut  <= '0;
      mRegOutB <= '0;
    end else if ((r_state == ST_IDLE && !w_is_mul) || r_state == ST_DONE) begin
      mwreg    <= ewreg;
      mm2reg   <= em2reg;
      mwmem    <= ewmem;
      mmux     <= emux;
      mAluOut  <= (r_state == ST_DONE) ? w_product : w_alu;
      mRegOutB <= eRegOutB;
    end else begin
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
      mmux   <= '0;
    end
  end

endmodule
